// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a registered one-hot grant,
// its binary index, and a bounded tenure timer. Each tenure is followed by at
// least one idle cycle (grant = 0) that serves as the resource handover bubble.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A limit of zero means a tenure is never cut short.
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam bit         HOLD_EN  = (MAX_HOLD != 0);

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] cur;
    logic [7:0] hold_cnt;

    logic       win_found;
    logic [2:0] win_idx;

    // Scan ptr, ptr+1, ... ptr+7 (3-bit wrap). The loop runs from the farthest
    // offset down so the nearest requester to ptr is the last one written.
    function automatic logic [3:0] find_winner(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] c;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            c = p + 3'(i);
            if (r[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    // Tenure counter saturates so an unlimited hold never wraps back to a
    // value that could match the limit.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Rotating-priority winner among the current requests.
    always_comb begin
        {win_found, win_idx} = find_winner(req, ptr);
    end

    // Arbitration state machine; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            cur         <= 3'd0;
            hold_cnt    <= 8'd0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && win_found) begin
                        state       <= BUSY;
                        cur         <= win_idx;
                        grant       <= 8'd1 << win_idx;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= 8'd1;
                    end else begin
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (!en) begin
                        // Enable drop wins over release and timeout; ptr keeps
                        // its value so the same owner can be re-granted.
                        state       <= IDLE;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                    end else if (!req[cur]) begin
                        state       <= IDLE;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                        ptr         <= cur + 3'd1;
                    end else if (HOLD_EN && (hold_cnt == HOLD_LIM)) begin
                        state       <= IDLE;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                        ptr         <= cur + 3'd1;
                        timeout     <= 1'b1;
                    end else begin
                        hold_cnt    <= sat_inc(hold_cnt);
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= 8'h00;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8. Three instances share the stimulus:
// MAX_HOLD=2 (main), MAX_HOLD=0 (unlimited) and MAX_HOLD=1 (single cycle).
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;

    logic [7:0] g2, g0, g1;
    logic [2:0] i2, i0, i1;
    logic       v2, v0, v1;
    logic       t2, t0, t1;

    int total = 0;
    int bad   = 0;

    rr_arbiter_8 #(.MAX_HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(g2), .grant_idx(i2), .grant_valid(v2), .timeout(t2)
    );

    rr_arbiter_8 #(.MAX_HOLD(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(g0), .grant_idx(i0), .grant_valid(v0), .timeout(t0)
    );

    rr_arbiter_8 #(.MAX_HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(g1), .grant_idx(i1), .grant_valid(v1), .timeout(t1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req   = 8'h00;
        en    = 1'b1;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    // Structural invariants on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            assert (((g2 & (g2 - 8'd1)) == 8'h00) && (v2 == (g2 != 8'h00)) &&
                    (!v2 || (g2 == (8'd1 << i2)))) else begin
                bad++;
                $error("FAIL inv_onehot observed grant=%0h idx=%0d valid=%0b expected one-hot matching idx",
                       g2, i2, v2);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;

        // Reset state
        step(2);
        chk("rst_grant", 32'(g2), 'h00);
        chk("rst_idx",   32'(i2), 'h0);
        chk("rst_valid", 32'(v2), 'h0);
        chk("rst_tout",  32'(t2), 'h0);
        en  = 1'b1;
        req = 8'h08;
        step(1);
        chk("rst_hold_grant", 32'(g2), 'h00);
        rst_n = 1'b1;

        // Single request, release, pointer advance
        step(1);
        chk("single_grant", 32'(g2), 'h08);
        chk("single_idx",   32'(i2), 'h3);
        chk("single_valid", 32'(v2), 'h1);
        req = 8'h00;
        step(1);
        chk("release_grant", 32'(g2), 'h00);
        chk("release_valid", 32'(v2), 'h0);
        chk("release_idx_hold", 32'(i2), 'h3);
        req = 8'h11;
        step(1);
        chk("ptr4_grant", 32'(g2), 'h10);
        chk("ptr4_idx",   32'(i2), 'h4);
        req = 8'h00;
        step(1);

        // Round-robin fairness with all requests held
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("rr_grant_a", 32'(g2), 32'd1 << k);
            chk("rr_idx",     32'(i2), 32'(k));
            if (k == 0) chk("h1_grant0", 32'(g1), 'h01);
            step(1);
            chk("rr_grant_b", 32'(g2), 32'd1 << k);
            chk("rr_tout_lo", 32'(t2), 'h0);
            if (k == 0) begin
                chk("h1_gap",  32'(g1), 'h00);
                chk("h1_tout", 32'(t1), 'h1);
            end
            step(1);
            chk("rr_gap",     32'(g2), 'h00);
            chk("rr_tout_hi", 32'(t2), 'h1);
            if (k == 0) chk("h1_grant1", 32'(g1), 'h02);
        end
        step(1);
        chk("rr_wrap_grant", 32'(g2), 'h01);
        chk("rr_wrap_idx",   32'(i2), 'h0);

        // Wrap-around from idx 7 to idx 0
        do_reset();
        req = 8'h40;
        step(1);
        chk("wrap_g6",   32'(g2), 'h40);
        chk("wrap_i6",   32'(i2), 'h6);
        req = 8'h00;
        step(1);
        chk("wrap_rel6", 32'(g2), 'h00);
        req = 8'h81;
        step(1);
        chk("wrap_g7",   32'(g2), 'h80);
        chk("wrap_i7",   32'(i2), 'h7);
        step(1);
        chk("wrap_g7b",  32'(g2), 'h80);
        step(1);
        chk("wrap_gap",  32'(g2), 'h00);
        chk("wrap_tout", 32'(t2), 'h1);
        step(1);
        chk("wrap_g0",   32'(g2), 'h01);
        chk("wrap_i0",   32'(i2), 'h0);

        // Enable override beats a pending timeout; ptr stays put
        do_reset();
        req = 8'h02;
        step(1);
        chk("en_g1", 32'(g2), 'h02);
        req = 8'h00;
        step(1);
        chk("en_rel1", 32'(g2), 'h00);
        req = 8'h04;
        step(1);
        chk("en_g2a", 32'(g2), 'h04);
        step(1);
        chk("en_g2b", 32'(g2), 'h04);
        en = 1'b0;
        step(1);
        chk("en_off_grant", 32'(g2), 'h00);
        chk("en_off_tout",  32'(t2), 'h0);
        en  = 1'b1;
        req = 8'h06;
        step(1);
        chk("en_regrant", 32'(g2), 'h04);
        chk("en_reidx",   32'(i2), 'h2);

        // Unlimited hold
        do_reset();
        req = 8'h11;
        for (int c = 0; c < 300; c++) begin
            step(1);
            chk("unl_grant", 32'(g0), 'h01);
            chk("unl_tout",  32'(t0), 'h0);
        end
        chk("unl_sat", 32'(u_h0.hold_cnt), 'hFF);
        req = 8'h10;
        step(1);
        chk("unl_rel", 32'(g0), 'h00);
        step(1);
        chk("unl_next_grant", 32'(g0), 'h10);
        chk("unl_next_idx",   32'(i0), 'h4);

        // Reset mid-tenure
        do_reset();
        req = 8'h08;
        step(1);
        chk("mid_g3", 32'(g2), 'h08);
        req = 8'h00;
        step(1);
        req = 8'h20;
        step(1);
        chk("mid_g5", 32'(g2), 'h20);
        chk("mid_i5", 32'(i2), 'h5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_async_grant", 32'(g2), 'h00);
        chk("mid_async_valid", 32'(v2), 'h0);
        chk("mid_async_idx",   32'(i2), 'h0);
        req = 8'h24;
        #1;
        rst_n = 1'b1;
        step(1);
        chk("mid_first_grant", 32'(g2), 'h04);
        chk("mid_first_idx",   32'(i2), 'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
